// File: rtl/csidh_fp_corr.sv
// csidh_fp_corr: final correction of a 9 x 57-bit CSIDH-512 element to
// its canonical residue mod p, one limb accepted and one limb emitted per cycle.
module csidh_fp_corr (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_last,
    output logic        busy
);
    localparam logic [63:0] MASK57 = 64'h01FF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

    state_t      state_q;
    logic [63:0] limb_q [9];
    logic [3:0]  idx_q;
    logic [63:0] carry_q;
    logic        mask_q;

    logic [63:0] p_i;
    logic [63:0] t;
    logic [63:0] u;
    logic        in_fire;
    logic        out_fire;
    logic        at_last;

    function automatic logic [63:0] p_limb(input logic [3:0] i);
        case (i)
            4'd0:    p_limb = 64'h0181B90533C6C87B;
            4'd1:    p_limb = 64'h010DFA2BD6541A8D;
            4'd2:    p_limb = 64'h003307C2D3C9709C;
            4'd3:    p_limb = 64'h00ACFE6AA0EA2CE6;
            4'd4:    p_limb = 64'h01322C9CDA7AAC6C;
            4'd5:    p_limb = 64'h00446212D7DFE634;
            4'd6:    p_limb = 64'h01312AD0B420EBB7;
            4'd7:    p_limb = 64'h017FF91561A2BC7C;
            4'd8:    p_limb = 64'h0065B48E8F740F89;
            default: p_limb = 64'h0;
        endcase
    endfunction

    assign in_ready  = (state_q != EMIT);
    assign out_valid = (state_q == EMIT);
    assign busy      = (state_q != IDLE);
    assign at_last   = (idx_q == 4'd8);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign p_i = p_limb(idx_q);
    assign t   = in_data - p_i + carry_q;
    // mask_q set means A - p went negative, so p is added back limb by limb
    assign u   = limb_q[idx_q] + (mask_q ? p_i : 64'h0) + carry_q;

    assign out_data = !out_valid ? 64'h0 : (at_last ? u : (u & MASK57));
    assign out_last = out_valid & at_last;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            carry_q <= 64'h0;
            mask_q  <= 1'b0;
            for (int k = 0; k < 9; k++) limb_q[k] <= 64'h0;
        end else begin
            case (state_q)
                IDLE, LOAD: begin
                    if (in_fire) begin
                        if (at_last) begin
                            limb_q[8] <= t;
                            mask_q    <= t[63];
                            carry_q   <= 64'h0;
                            idx_q     <= 4'd0;
                            state_q   <= EMIT;
                        end else begin
                            limb_q[idx_q] <= t & MASK57;
                            carry_q       <= $signed(t) >>> 57;
                            idx_q         <= idx_q + 4'd1;
                            state_q       <= LOAD;
                        end
                    end
                end
                EMIT: begin
                    if (out_fire) begin
                        if (at_last) begin
                            state_q <= IDLE;
                            idx_q   <= 4'd0;
                            carry_q <= 64'h0;
                            mask_q  <= 1'b0;
                        end else begin
                            carry_q <= $signed(u) >>> 57;
                            idx_q   <= idx_q + 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csidh_fp_corr.sv
// Directed bench for csidh_fp_corr: hand-computed residues, input gaps,
// output backpressure and mid-element reset.
module tb_csidh_fp_corr;
    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = 64'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        out_last;
    logic        busy;

    int errors = 0;
    int checks = 0;

    localparam logic [63:0] PL [9] = '{
        64'h0181B90533C6C87B, 64'h010DFA2BD6541A8D, 64'h003307C2D3C9709C,
        64'h00ACFE6AA0EA2CE6, 64'h01322C9CDA7AAC6C, 64'h00446212D7DFE634,
        64'h01312AD0B420EBB7, 64'h017FF91561A2BC7C, 64'h0065B48E8F740F89};

    logic [63:0] vec [9];
    logic [63:0] exp_v [9];

    csidh_fp_corr dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy));

    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic run_elem(input string name, input int gap_len,
                            input int stall_len);
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i == 4) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge g_clk);
                    in_valid = 1'b0;
                    chk({name, " gap busy"}, 64'(busy), 64'd1);
                end
            end
            @(negedge g_clk);
            in_valid = 1'b1;
            in_data  = vec[i];
            chk({name, " in_ready"}, 64'(in_ready), 64'd1);
            chk({name, " no out during load"}, 64'(out_valid), 64'd0);
        end
        @(negedge g_clk);
        in_valid = 1'b0;
        chk({name, " latency out_valid"}, 64'(out_valid), 64'd1);
        for (int k = 0; k < 9; k++) begin
            if (k == 4) begin
                for (int s = 0; s < stall_len; s++) begin
                    out_ready = 1'b0;
                    chk({name, " stall data"}, out_data, exp_v[k]);
                    chk({name, " stall last"}, 64'(out_last), 64'd0);
                    chk({name, " stall busy"}, 64'(busy), 64'd1);
                    @(negedge g_clk);
                end
            end
            out_ready = 1'b1;
            chk({name, " out_valid"}, 64'(out_valid), 64'd1);
            chk({name, " in_ready low"}, 64'(in_ready), 64'd0);
            chk({name, $sformatf(" limb%0d", k)}, out_data, exp_v[k]);
            chk({name, " out_last"}, 64'(out_last), 64'(k == 8));
            @(negedge g_clk);
        end
        out_ready = 1'b0;
        chk({name, " done out_valid"}, 64'(out_valid), 64'd0);
        chk({name, " done busy"}, 64'(busy), 64'd0);
        chk({name, " done in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #1;
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_data", out_data, 64'd0);
        chk("rst out_last", 64'(out_last), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        repeat (2) @(negedge g_clk);
        g_resetn = 1'b1;

        // A = p -> 0
        for (int i = 0; i < 9; i++) begin vec[i] = PL[i]; exp_v[i] = 64'h0; end
        run_elem("p", 0, 0);

        // A = p + 1 -> 1
        vec[0] = PL[0] + 64'd1;
        exp_v[0] = 64'd1;
        run_elem("p+1", 0, 0);

        // A = 5 -> 5 through the add-back path
        for (int i = 0; i < 9; i++) begin vec[i] = 64'h0; exp_v[i] = 64'h0; end
        vec[0] = 64'd5;
        exp_v[0] = 64'd5;
        run_elem("five", 0, 0);

        // A = p - 1 -> p - 1 (largest canonical value)
        for (int i = 0; i < 9; i++) begin vec[i] = PL[i]; exp_v[i] = PL[i]; end
        vec[0] = PL[0] - 64'd1;
        exp_v[0] = PL[0] - 64'd1;
        run_elem("p-1", 0, 0);

        // A = 2p - 1 with oversized limbs -> p - 1
        for (int i = 0; i < 9; i++) vec[i] = PL[i] << 1;
        vec[0] = (PL[0] << 1) - 64'd1;
        run_elem("2p-1", 0, 0);

        // A = 2^57 carried into limb0 -> limb1 = 1
        for (int i = 0; i < 9; i++) begin vec[i] = 64'h0; exp_v[i] = 64'h0; end
        vec[0] = 64'h0200000000000000;
        exp_v[1] = 64'd1;
        run_elem("2^57", 0, 0);
        run_elem("2^57 gaps", 2, 3);

        // reset after 5 limbs loaded
        for (int i = 0; i < 9; i++) begin vec[i] = PL[i]; exp_v[i] = 64'h0; end
        for (int i = 0; i < 5; i++) begin
            @(negedge g_clk);
            in_valid = 1'b1;
            in_data  = vec[i];
        end
        @(negedge g_clk);
        in_valid = 1'b0;
        chk("mid busy", 64'(busy), 64'd1);
        g_resetn = 1'b0;
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort in_ready", 64'(in_ready), 64'd1);
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort out_data", out_data, 64'd0);
        chk("abort out_last", 64'(out_last), 64'd0);
        @(negedge g_clk);
        g_resetn = 1'b1;
        run_elem("p after reset", 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
